fill_line_sequencer: RTL and testbench

- Top-level sequencer for the bottle filling line. Drives the conveyor motor relay and the pump relay from the debounced fill-station IR sensor and the operator start/stop/clear inputs.
- Per bottle: convey until a bottle reaches the nozzle, stop the belt, let it settle, fill for a fixed time, wait a drip interval, then convey until the bottle leaves the sensor.
- Maintains a filled-bottle counter and flags faults: bottle missing, bottle removed mid-fill, bottle stuck.

---
 rtl/fill_line_sequencer.sv | 157 +++++++++++++++
 tb/tb_fill_line_sequencer.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fill_line_sequencer.sv
// Bottle filling line sequencer: drives conveyor and pump relays from the fill-station IR sensor and operator buttons.
// state | meaning: IDLE parked | CONVEY feeding | SETTLE belt stopped | FILL pump on | DRIP wait | RELEASE eject | FAULT halted
module fill_line_sequencer #(
  parameter int unsigned CNT_W           = 36,
  parameter int unsigned DEBOUNCE_CYCLES = 500_000,
  parameter int unsigned SETTLE_CYCLES   = 25_000_000,
  parameter int unsigned FILL_CYCLES     = 500_000_000,
  parameter int unsigned DRIP_CYCLES     = 100_000_000,
  parameter int unsigned ARRIVE_TIMEOUT  = 1_500_000_000,
  parameter int unsigned RELEASE_TIMEOUT = 250_000_000,
  parameter logic [15:0] COUNT_INIT      = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_btn,
  input  logic        stop_btn,
  input  logic        clear_fault,
  input  logic        ir_fill,
  output logic        motor_switch,
  output logic        pumpa_switch,
  output logic        dioda_punjenje,
  output logic        fault_led,
  output logic [15:0] bottle_count,
  output logic [2:0]  state_o
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CONVEY  = 3'd1,
    SETTLE  = 3'd2,
    FILL    = 3'd3,
    DRIP    = 3'd4,
    RELEASE = 3'd5,
    FAULT   = 3'd6
  } state_t;

  localparam int unsigned DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DB_W-1:0]  DB_LAST      = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] FILL_LAST    = CNT_W'(FILL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DRIP_LAST    = CNT_W'(DRIP_CYCLES - 1);
  localparam logic [CNT_W-1:0] ARRIVE_LAST  = CNT_W'(ARRIVE_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] RELEASE_LAST = CNT_W'(RELEASE_TIMEOUT - 1);

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt;
  logic [DB_W-1:0]  db_cnt;
  logic             bottle;
  logic             stop_pend;
  logic [3:0]       sync1, sync2;
  logic [2:0]       btn_prev;
  logic             start_p, stop_p, clear_p;
  logic             present_sync;
  logic             timed;

  // sync bit order {ir_fill, clear, stop, start}; ir_fill idles high (no bottle)
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1    <= 4'b1000;
      sync2    <= 4'b1000;
      btn_prev <= 3'b000;
    end else begin
      sync1    <= {ir_fill, clear_fault, stop_btn, start_btn};
      sync2    <= sync1;
      btn_prev <= sync2[2:0];
    end
  end

  assign start_p      = sync2[0] & ~btn_prev[0];
  assign stop_p       = sync2[1] & ~btn_prev[1];
  assign clear_p      = sync2[2] & ~btn_prev[2];
  assign present_sync = ~sync2[3];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bottle <= 1'b0;
      db_cnt <= '0;
    end else if (present_sync != bottle) begin
      if (db_cnt == DB_LAST) begin
        bottle <= present_sync;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + DB_W'(1);
      end
    end else begin
      db_cnt <= '0;
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (start_p && !stop_p) state_n = CONVEY;
      CONVEY: begin
        if (stop_p)                   state_n = IDLE;
        else if (bottle)              state_n = SETTLE;
        else if (cnt == ARRIVE_LAST)  state_n = FAULT;
      end
      SETTLE:  if (cnt == SETTLE_LAST) state_n = FILL;
      FILL: begin
        if (!bottle)                  state_n = FAULT;
        else if (cnt == FILL_LAST)    state_n = DRIP;
      end
      DRIP:    if (cnt == DRIP_LAST) state_n = RELEASE;
      RELEASE: begin
        if (!bottle)                  state_n = (stop_pend || stop_p) ? IDLE : CONVEY;
        else if (cnt == RELEASE_LAST) state_n = FAULT;
      end
      FAULT:   if (clear_p) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign timed = (state == CONVEY) || (state == SETTLE) || (state == FILL) ||
                 (state == DRIP) || (state == RELEASE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      if (state_n != state) cnt <= '0;
      else if (timed)       cnt <= cnt + CNT_W'(1);
    end
  end

  // a stop arriving mid-bottle is held until the bottle has left the sensor
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stop_pend <= 1'b0;
    end else if ((state == RELEASE && state_n != RELEASE) || (state == FAULT && clear_p)) begin
      stop_pend <= 1'b0;
    end else if (stop_p && (state == SETTLE || state == FILL || state == DRIP || state == RELEASE)) begin
      stop_pend <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      motor_switch <= 1'b1;
      pumpa_switch <= 1'b1;
      fault_led    <= 1'b0;
      bottle_count <= COUNT_INIT;
    end else begin
      motor_switch <= !((state_n == CONVEY) || (state_n == RELEASE));
      pumpa_switch <= (state_n != FILL);
      fault_led    <= (state_n == FAULT);
      if (state == FILL && state_n == DRIP && bottle_count != 16'hFFFF)
        bottle_count <= bottle_count + 16'd1;
    end
  end

  assign dioda_punjenje = pumpa_switch;
  assign state_o        = state;

endmodule

// File: tb/tb_fill_line_sequencer.sv
// Scoreboard bench for fill_line_sequencer: expected state transitions, dwell times and bottle counts are queued
// from the line's timing rules and checked by an independent monitor on every observed state change.
module tb_fill_line_sequencer;
  localparam int D   = 4;
  localparam int SET = 5;
  localparam int FIL = 20;
  localparam int DRP = 6;
  localparam int ARR = 100;
  localparam int REL = 30;
  localparam logic [15:0] CINIT = 16'hFFFD;

  localparam logic [2:0] S_IDLE = 3'd0, S_CONVEY = 3'd1, S_SETTLE = 3'd2, S_FILL = 3'd3,
                         S_DRIP = 3'd4, S_RELEASE = 3'd5, S_FAULT = 3'd6;

  logic clk = 1'b0, rst_n = 1'b0, start_btn = 1'b0, stop_btn = 1'b0, clear_fault = 1'b0, ir_fill = 1'b1;
  logic        motor_switch, pumpa_switch, dioda_punjenje, fault_led;
  logic [15:0] bottle_count;
  logic [2:0]  state_o;

  int compared = 0;
  int mismatched = 0;

  typedef struct {
    logic [2:0]  st;
    int          dur;
    logic [15:0] cnt;
  } exp_t;

  exp_t       expq[$];
  exp_t       e;
  int         model_count;
  bit         mon_en = 1'b0;
  logic [2:0] prev_st;
  int         dur;

  always #5 clk = ~clk;

  fill_line_sequencer #(
    .CNT_W(36), .DEBOUNCE_CYCLES(D), .SETTLE_CYCLES(SET), .FILL_CYCLES(FIL),
    .DRIP_CYCLES(DRP), .ARRIVE_TIMEOUT(ARR), .RELEASE_TIMEOUT(REL), .COUNT_INIT(CINIT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start_btn(start_btn), .stop_btn(stop_btn),
    .clear_fault(clear_fault), .ir_fill(ir_fill), .motor_switch(motor_switch),
    .pumpa_switch(pumpa_switch), .dioda_punjenje(dioda_punjenje), .fault_led(fault_led),
    .bottle_count(bottle_count), .state_o(state_o)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [2:0] st, input int d);
    exp_t x;
    x.st  = st;
    x.dur = d;
    x.cnt = 16'(model_count);
    expq.push_back(x);
  endtask

  task automatic pulse(input logic st, input logic sp, input logic cl);
    start_btn = st; stop_btn = sp; clear_fault = cl;
    @(negedge clk);
    start_btn = 1'b0; stop_btn = 1'b0; clear_fault = 1'b0;
  endtask

  task automatic wait_state(input logic [2:0] st, input int limit);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (state_o !== st && n < limit);
    if (state_o !== st) begin
      compared++;
      mismatched++;
      $display("FAIL wait_state: state %0d, required %0d within %0d cycles", state_o, st, limit);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_motor"}, 32'(motor_switch), 32'd1);
    check({tag, "_pump"},  32'(pumpa_switch), 32'd1);
    check({tag, "_dioda"}, 32'(dioda_punjenje), 32'd1);
    check({tag, "_fault"}, 32'(fault_led), 32'd0);
    check({tag, "_count"}, 32'(bottle_count), 32'(CINIT));
    check({tag, "_state"}, 32'(state_o), 32'(S_IDLE));
  endtask

  // one bottle starting at the first observed CONVEY cycle; stop_at<0 means no stop request
  task automatic fill_one(input int a, input int b, input int stop_at);
    repeat (a) @(negedge clk);
    ir_fill = 1'b0;
    push(S_SETTLE, a + D + 3);
    push(S_FILL, SET);
    model_count = (model_count >= 65535) ? 65535 : model_count + 1;
    push(S_DRIP, FIL);
    push(S_RELEASE, DRP);
    wait_state(S_FILL, a + D + SET + 10);
    if (stop_at >= 0) begin
      repeat (stop_at) @(negedge clk);
      pulse(1'b0, 1'b1, 1'b0);
    end
    wait_state(S_RELEASE, FIL + DRP + 10);
    repeat (b) @(negedge clk);
    ir_fill = 1'b1;
    if (stop_at >= 0) begin
      push(S_IDLE, b + D + 3);
      wait_state(S_IDLE, b + D + 10);
    end else begin
      push(S_CONVEY, b + D + 3);
      wait_state(S_CONVEY, b + D + 10);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      check("motor_vs_state", 32'(motor_switch), 32'(!(state_o == S_CONVEY || state_o == S_RELEASE)));
      check("pump_vs_state",  32'(pumpa_switch), 32'(state_o != S_FILL));
      check("dioda_vs_state", 32'(dioda_punjenje), 32'(state_o != S_FILL));
      check("led_vs_state",   32'(fault_led), 32'(state_o == S_FAULT));
      if (state_o !== prev_st) begin
        if (expq.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL unexpected_transition: got %0d -> %0d, required no change", prev_st, state_o);
        end else begin
          e = expq.pop_front();
          check("next_state", 32'(state_o), 32'(e.st));
          if (e.dur >= 0) check("dwell_cycles", 32'(dur), 32'(e.dur));
          check("bottle_count", 32'(bottle_count), 32'(e.cnt));
        end
        prev_st = state_o;
        dur = 1;
      end else begin
        dur++;
      end
    end
  end

  initial begin
    int a, b, n;
    model_count = int'(CINIT);
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n   = 1'b1;
    prev_st = S_IDLE;
    dur     = 0;
    mon_en  = 1'b1;
    repeat (5) @(negedge clk);

    // start and stop together: stop wins
    pulse(1'b1, 1'b1, 1'b0);
    repeat (10) @(negedge clk);

    // arrival timeout, start ignored in FAULT, clear back to IDLE
    push(S_CONVEY, -1);
    pulse(1'b1, 1'b0, 1'b0);
    wait_state(S_CONVEY, 10);
    push(S_FAULT, ARR);
    wait_state(S_FAULT, ARR + 10);
    pulse(1'b1, 1'b0, 1'b0);
    repeat (6) @(negedge clk);
    push(S_IDLE, -1);
    pulse(1'b0, 1'b0, 1'b1);
    wait_state(S_IDLE, 10);

    // short sensor glitch must not count as an arrival; stop in CONVEY parks immediately
    push(S_CONVEY, -1);
    pulse(1'b1, 1'b0, 1'b0);
    wait_state(S_CONVEY, 10);
    ir_fill = 1'b0;
    repeat (2) @(negedge clk);
    ir_fill = 1'b1;
    repeat (5) @(negedge clk);
    push(S_IDLE, 10);
    pulse(1'b0, 1'b1, 1'b0);
    wait_state(S_IDLE, 15);

    // three bottles: counter reaches 16'hFFFF and then saturates; last one stopped mid-fill
    push(S_CONVEY, -1);
    pulse(1'b1, 1'b0, 1'b0);
    wait_state(S_CONVEY, 10);
    fill_one(10, 4, -1);
    fill_one(int'($urandom_range(0, 30)), int'($urandom_range(0, 15)), -1);
    fill_one(int'($urandom_range(0, 30)), int'($urandom_range(0, 15)), int'($urandom_range(0, 10)));

    // bottle removed mid-fill
    push(S_CONVEY, -1);
    pulse(1'b1, 1'b0, 1'b0);
    wait_state(S_CONVEY, 10);
    a = int'($urandom_range(0, 30));
    repeat (a) @(negedge clk);
    ir_fill = 1'b0;
    push(S_SETTLE, a + D + 3);
    push(S_FILL, SET);
    wait_state(S_FILL, a + D + SET + 10);
    repeat (8) @(negedge clk);
    ir_fill = 1'b1;
    push(S_FAULT, 8 + D + 3);
    wait_state(S_FAULT, D + 20);
    push(S_IDLE, -1);
    pulse(1'b0, 1'b0, 1'b1);
    wait_state(S_IDLE, 10);

    // reset asserted during FILL
    push(S_CONVEY, -1);
    pulse(1'b1, 1'b0, 1'b0);
    wait_state(S_CONVEY, 10);
    a = int'($urandom_range(0, 30));
    repeat (a) @(negedge clk);
    ir_fill = 1'b0;
    push(S_SETTLE, a + D + 3);
    push(S_FILL, SET);
    wait_state(S_FILL, a + D + SET + 10);
    repeat (5) @(negedge clk);
    model_count = int'(CINIT);
    push(S_IDLE, -1);
    rst_n   = 1'b0;
    ir_fill = 1'b1;
    @(negedge clk);
    check_reset_outputs("midfill_reset");
    rst_n = 1'b1;
    repeat (10) @(negedge clk);

    // one more bottle after reset, parked by a stop during FILL
    push(S_CONVEY, -1);
    pulse(1'b1, 1'b0, 1'b0);
    wait_state(S_CONVEY, 10);
    b = int'($urandom_range(0, 15));
    fill_one(int'($urandom_range(0, 30)), b, 3);

    n = 0;
    while (expq.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (expq.size() != 0) begin
      compared++;
      mismatched++;
      $display("FAIL drain: %0d expected transitions never seen, required 0", expq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
